i2c_master_ctrl: RTL

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

---
 rtl/i2c_ctrl_pkg.sv | 33 +++
 rtl/i2c_phase_timer.sv | 65 ++++++
 rtl/i2c_master_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_ctrl_pkg.sv
// rtl/i2c_ctrl_pkg.sv - shared types and widths for the I2C register-access master.
// Build option I2C_CLK_STRETCH_EN is consumed by i2c_phase_timer.
package i2c_ctrl_pkg;

    localparam int ADDR_W = 7;
    localparam int BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        START,
        WADDR,
        WACK1,
        INDEX,
        WACK2,
        WDATA,
        WACK3,
        RESTART,
        RADDR,
        RACK,
        RDATA,
        MNACK,
        STOP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        PH0,
        PH1,
        PH2,
        PH3
    } phase_t;

endpackage

// File: rtl/i2c_phase_timer.sv
// rtl/i2c_phase_timer.sv - divides each bit slot into four CLK_DIV-cycle phases.
// With I2C_CLK_STRETCH_EN defined, P2 waits while a slave holds SCL low.
module i2c_phase_timer
    import i2c_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic   clk,
    input  logic   RST_N,
    input  logic   run_i,
    input  logic   scl_rel_i,
    input  logic   scl_i,
    output phase_t phase_o,
    output logic   first_o,
    output logic   slot_end_o
);

    localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    phase_t     phase_q, phase_d;
    logic       adv;
    logic       last;

`ifdef I2C_CLK_STRETCH_EN
    // Only stall when we have released SCL and the line is still low.
    assign adv = !(phase_q == PH2 && scl_rel_i && !scl_i);
`else
    logic unused_stretch;
    assign unused_stretch = scl_rel_i ^ scl_i;
    assign adv = 1'b1;
`endif

    assign last       = (cnt_q == CNT_LAST);
    assign phase_o    = phase_q;
    assign first_o    = (cnt_q == 8'd0);
    assign slot_end_o = run_i && adv && last && (phase_q == PH3);

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run_i) begin
            cnt_d   = 8'd0;
            phase_d = PH0;
        end else if (adv) begin
            if (last) begin
                cnt_d   = 8'd0;
                phase_d = phase_t'(phase_q + 2'd1);
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q   <= 8'd0;
            phase_q <= PH0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-register I2C write/read master with open-drain line controls.
// Optional slave clock stretching via I2C_CLK_STRETCH_EN (see i2c_phase_timer).
module i2c_master_ctrl
    import i2c_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [BYTE_W-1:0] cmd_index,
    input  logic [BYTE_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [BYTE_W-1:0] rsp_rdata,
    output logic              rsp_nack,
    output logic              busy,
    input  logic              scl_i,
    output logic              scl_oe,
    input  logic              sda_i,
    output logic              sda_oe
);

    state_t            state_q, state_d;
    logic [2:0]        bit_q, bit_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] idx_q, idx_d;
    logic [BYTE_W-1:0] wdata_q, wdata_d;
    logic [BYTE_W-1:0] rdata_q, rdata_d;
    logic              samp_q, samp_d;
    logic              nack_q, nack_d;
    logic              sda_prev_q;

    phase_t            phase;
    logic              first;
    logic              slot_end;
    logic              run;
    logic [BYTE_W-1:0] tx_byte;
    logic              bit_pull;

    assign run       = (state_q != IDLE) && (state_q != DONE);
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_nack  = nack_q;

    i2c_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk       (clk),
        .RST_N     (RST_N),
        .run_i     (run),
        .scl_rel_i (!scl_oe),
        .scl_i     (scl_i),
        .phase_o   (phase),
        .first_o   (first),
        .slot_end_o(slot_end)
    );

    // Non-transmit slots (ACKs, RDATA, MNACK) use all-ones so SDA stays released.
    always_comb begin
        case (state_q)
            WADDR:   tx_byte = {addr_q, 1'b0};
            INDEX:   tx_byte = idx_q;
            WDATA:   tx_byte = wdata_q;
            RADDR:   tx_byte = {addr_q, 1'b1};
            default: tx_byte = 8'hFF;
        endcase
    end
    assign bit_pull = ~tx_byte[3'd7 - bit_q];

    // In P0 of a bit slot SDA keeps its previous level so it never moves as SCL falls.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            IDLE, DONE: ;
            START: begin
                sda_oe = (phase != PH0);
                scl_oe = (phase == PH2) || (phase == PH3);
            end
            RESTART: begin
                sda_oe = (phase == PH2) || (phase == PH3);
                scl_oe = (phase == PH0) || (phase == PH3);
            end
            STOP: begin
                sda_oe = (phase == PH0) || (phase == PH1);
                scl_oe = (phase == PH0);
            end
            default: begin
                scl_oe = (phase == PH0) || (phase == PH1);
                sda_oe = (phase == PH0) ? sda_prev_q : bit_pull;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        samp_d  = samp_q;
        nack_d  = nack_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = START;
                    rw_d    = cmd_rw;
                    addr_d  = cmd_addr;
                    idx_d   = cmd_index;
                    wdata_d = cmd_wdata;
                    rdata_d = '0;
                    nack_d  = 1'b0;
                    bit_d   = 3'd0;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (slot_end) begin
                    case (state_q)
                        START:   state_d = WADDR;
                        RESTART: state_d = RADDR;
                        MNACK:   state_d = STOP;
                        STOP:    state_d = DONE;
                        WADDR, INDEX, WDATA, RADDR, RDATA: begin
                            bit_d = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                case (state_q)
                                    WADDR:   state_d = WACK1;
                                    INDEX:   state_d = WACK2;
                                    WDATA:   state_d = WACK3;
                                    RADDR:   state_d = RACK;
                                    default: state_d = MNACK;
                                endcase
                            end
                        end
                        WACK1, WACK2, WACK3, RACK: begin
                            if (samp_q) begin
                                nack_d  = 1'b1;
                                state_d = STOP;
                            end else begin
                                case (state_q)
                                    WACK1:   state_d = INDEX;
                                    WACK2:   state_d = rw_q ? RESTART : WDATA;
                                    WACK3:   state_d = STOP;
                                    default: state_d = RDATA;
                                endcase
                            end
                        end
                        default: state_d = state_q;
                    endcase
                end
            end
        endcase
        if (run && phase == PH2 && first) begin
            samp_d = sda_i;
            if (state_q == RDATA) rdata_d = {rdata_q[BYTE_W-2:0], sda_i};
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            bit_q      <= 3'd0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            samp_q     <= 1'b0;
            nack_q     <= 1'b0;
            sda_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            samp_q     <= samp_d;
            nack_q     <= nack_d;
            sda_prev_q <= sda_oe;
        end
    end

endmodule
